// File: rtl/ms_pulse_sched_if.sv
// Button, duration and status bundle between the board/top level and the
// millisecond run controller.
interface ms_pulse_sched_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] dur_ms;
  logic             ms_tick;
  logic             busy;
  logic             paused;
  logic             done;
  logic [CNT_W-1:0] remaining_ms;
  logic             led;

  modport master (
    output start, stop, dur_ms,
    input  ms_tick, busy, paused, done, remaining_ms, led
  );

  modport slave (
    input  start, stop, dur_ms,
    output ms_tick, busy, paused, done, remaining_ms, led
  );
endinterface

// File: rtl/ms_pulse_sched.sv
// Run controller for the millisecond pulse path: synchronizes the raw
// start/stop buttons, owns the CLK_HZ/TICK_HZ prescaler and counts a loaded
// duration down (or elapsed ticks up in free-run) with pause/resume.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | no run; all outputs low, remaining 0
//  S_RUN   | prescaler advancing, ms_tick pulses, led toggles per tick
//  S_PAUSE | prescaler and remaining frozen, partial tick kept
//  S_DONE  | countdown reached 0; led held on until start or stop
module ms_pulse_sched #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  ms_pulse_sched_if.slave   bus
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PC_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PC_W-1:0] PC_MAX = PC_W'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             free_q, free_d;
  logic             led_q, led_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             paused_q, paused_d;
  logic             done_q, done_d;

  logic start_s1_q, start_s1_d, start_s2_q, start_s2_d, start_r_q, start_r_d;
  logic stop_s1_q, stop_s1_d, stop_s2_q, stop_s2_d, stop_r_q, stop_r_d;
  logic start_p, stop_p;

  // Two-flop synchronizers plus edge registers; each press yields one pulse.
  always_comb begin
    start_s1_d = bus.start;
    start_s2_d = start_s1_q;
    start_r_d  = start_s2_q;
    stop_s1_d  = bus.stop;
    stop_s2_d  = stop_s1_q;
    stop_r_d   = stop_s2_q;
    start_p    = start_s2_q & ~start_r_q;
    stop_p     = stop_s2_q & ~stop_r_q;
  end

  // Next-state, prescaler, counter and led; stop beats start and beats a tick.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rem_d   = rem_q;
    free_d  = free_q;
    led_d   = led_q;
    tick_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!stop_p && start_p) begin
          state_d = S_RUN;
          pc_d    = '0;
          rem_d   = bus.dur_ms;
          free_d  = (bus.dur_ms == '0);
          led_d   = 1'b0;
        end
      end

      S_RUN: begin
        if (stop_p) begin
          // Tick in this cycle is dropped; pc holds so the partial tick survives.
          state_d = S_PAUSE;
        end else if (pc_q == PC_MAX) begin
          tick_d = 1'b1;
          pc_d   = '0;
          led_d  = ~led_q;
          if (free_q) begin
            rem_d = rem_q + CNT_W'(1);
          end else if (rem_q == CNT_W'(1)) begin
            rem_d   = '0;
            state_d = S_DONE;
            led_d   = 1'b1;
          end else begin
            rem_d = rem_q - CNT_W'(1);
          end
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end

      S_PAUSE: begin
        if (stop_p) begin
          state_d = S_IDLE;
          rem_d   = '0;
          led_d   = 1'b0;
        end else if (start_p) begin
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        if (stop_p) begin
          state_d = S_IDLE;
          rem_d   = '0;
          led_d   = 1'b0;
        end else if (start_p) begin
          state_d = S_RUN;
          pc_d    = '0;
          rem_d   = bus.dur_ms;
          free_d  = (bus.dur_ms == '0);
          led_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        rem_d   = '0;
        led_d   = 1'b0;
      end
    endcase

    busy_d   = (state_d == S_RUN);
    paused_d = (state_d == S_PAUSE);
    done_d   = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      rem_q      <= '0;
      free_q     <= 1'b0;
      led_q      <= 1'b0;
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
      paused_q   <= 1'b0;
      done_q     <= 1'b0;
      start_s1_q <= 1'b0;
      start_s2_q <= 1'b0;
      start_r_q  <= 1'b0;
      stop_s1_q  <= 1'b0;
      stop_s2_q  <= 1'b0;
      stop_r_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rem_q      <= rem_d;
      free_q     <= free_d;
      led_q      <= led_d;
      tick_q     <= tick_d;
      busy_q     <= busy_d;
      paused_q   <= paused_d;
      done_q     <= done_d;
      start_s1_q <= start_s1_d;
      start_s2_q <= start_s2_d;
      start_r_q  <= start_r_d;
      stop_s1_q  <= stop_s1_d;
      stop_s2_q  <= stop_s2_d;
      stop_r_q   <= stop_r_d;
    end
  end

  assign bus.ms_tick      = tick_q;
  assign bus.busy         = busy_q;
  assign bus.paused       = paused_q;
  assign bus.done         = done_q;
  assign bus.remaining_ms = rem_q;
  assign bus.led          = led_q;

endmodule
